// File: rtl/pbg_pkg.sv
// pbg_pkg: shared definitions for the 4-bit parity link transmitter.
//   WORD_W      - data word width (4: bits a..d)
//   FRAME_BITS  - serial bits per frame (start + 4 data + parity + stop)
//   IDLE..STOP  - transmitter FSM state encodings (3-bit)
//   word_t      - data word type
package pbg_pkg;

  localparam int WORD_W     = 4;
  localparam int FRAME_BITS = 7;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/pbg_parity_gen.sv
// pbg_parity_gen: combinational parity of one data word.
//   data_i   [WORD_W] - word to protect
//   odd_i             - 0: even parity (XOR of all bits incl. parity is 0)
//                       1: odd parity  (XOR of all bits incl. parity is 1)
//   parity_o          - parity bit to append to the word
module pbg_parity_gen
  import pbg_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic              odd_i,
  output logic              parity_o
);

  assign parity_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/pbg_serial_tx.sv
// pbg_serial_tx: parity-bit generator and framed serial transmitter.
// Accepts a 4-bit word on a valid/ready handshake and sends
// start(0), d[0..3] LSB first, parity, stop(1), each CLKS_PER_BIT cycles.
// The accepted word and its parity are also held on word_out/p_out.
//
// Build option: define PBG_ODD_PARITY_EN for odd parity; the default
// (macro undefined) is even parity.
//
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous active-high reset
//   data_in[4]  - word to send (bit 0 = a, bit 3 = d)
//   data_valid  - data_in is valid
//   data_ready  - transmitter idle, will accept a word
//   tx_out      - serial line, idles high
//   word_out[4] - last accepted word
//   p_out       - parity of word_out
//   busy        - frame in progress
//   frame_done  - one-cycle pulse during the last stop-bit cycle
module pbg_serial_tx
  import pbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_out,
  output logic [WORD_W-1:0] word_out,
  output logic              p_out,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [7:0] LAST_BAUD = 8'(CLKS_PER_BIT - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        baud_q, baud_d;
  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              p_q, p_d;
  logic              tx_q, tx_d;
  logic              ready_q, busy_q;
  logic              done_q, done_d;
  logic              bit_end;
  logic              odd_sel;
  logic              par_in;

`ifdef PBG_ODD_PARITY_EN
  assign odd_sel = 1'b1;
`else
  assign odd_sel = 1'b0;
`endif

  pbg_parity_gen u_parity (
    .data_i   (data_in),
    .odd_i    (odd_sel),
    .parity_o (par_in)
  );

  assign bit_end = (baud_q == LAST_BAUD);

  // Next-state logic for FSM, baud counter, bit index and captured word.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    word_d  = word_q;
    p_d     = p_q;

    case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_d = START;
          baud_d  = 8'd0;
          idx_d   = 2'd0;
          word_d  = data_in;
          p_d     = par_in;
        end
      end
      START:   if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          if (idx_q == 2'd3) state_d = PARITY;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) baud_d = bit_end ? 8'd0 : baud_q + 8'd1;
  end

  // Outputs are computed from the next state so that, once registered,
  // they line up with the state they describe (tx falls right after accept).
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = word_d[idx_d];
      PARITY:  tx_d = p_d;
      default: tx_d = 1'b1;
    endcase
    done_d = (state_d == STOP) && (baud_d == LAST_BAUD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 8'd0;
      idx_q   <= 2'd0;
      word_q  <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign data_ready = ready_q;
  assign tx_out     = tx_q;
  assign word_out   = word_q;
  assign p_out      = p_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pbg_serial_tx.sv
// Self-checking bench for pbg_serial_tx: reset, directed words, all 16 words
// back-to-back, ignored mid-frame words, random words with input noise and a
// mid-frame reset. Expected serial frames come from a per-word bit list.
module tb_pbg_serial_tx;
  import pbg_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;
`ifdef PBG_ODD_PARITY_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx_out;
  logic [3:0] word_out;
  logic       p_out;
  logic       busy;
  logic       frame_done;

  int cyc         = 0;
  int n_checks    = 0;
  int n_fail      = 0;
  int last_accept = -1;

  pbg_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_out     (tx_out),
    .word_out   (word_out),
    .p_out      (p_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference parity: count ones, even parity unless the odd build is selected.
  function automatic logic ref_parity(input logic [3:0] w);
    int ones;
    ones = $countones(w);
    return 1'(ones % 2) ^ ODD;
  endfunction

  // mode 0: quiet inputs, 1: random valid/data noise, 2: pulse 4'b0110 in DATA
  task automatic run_frame(input logic [3:0] w, input int mode, input bit next_valid,
                           input logic [3:0] next_w, input bit check_gap);
    logic exp_bits [7];
    logic p;
    int   waited;
    p = ref_parity(w);
    exp_bits = '{1'b0, w[0], w[1], w[2], w[3], p, 1'b1};
    data_in    = w;
    data_valid = 1'b1;
    waited = 0;
    while (data_ready !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    if (waited >= 100) chk("ready_timeout", 32'(0), 32'(1));
    step();  // accept edge
    if (check_gap && last_accept >= 0) chk("accept_gap", 32'(cyc - last_accept), 32'(FRAME_CYC + 1));
    last_accept = cyc;
    data_valid = 1'b0;
    chk("word_out", 32'(word_out), 32'(w));
    chk("p_out", 32'(p_out), 32'(p));
    chk("pec", 32'(^{word_out, p_out}), 32'(ODD));
    chk("ready_busy", 32'({data_ready, busy}), 32'(2'b01));
    for (int k = 0; k < FRAME_CYC; k++) begin
      chk("tx_out", 32'(tx_out), 32'(exp_bits[k / CPB]));
      chk("frame_done", 32'(frame_done), 32'(k == FRAME_CYC - 1));
      chk("busy", 32'(busy), 32'(1));
      if (mode == 1) begin
        data_valid = 1'($urandom_range(0, 1));
        data_in    = 4'($urandom);
      end else if (mode == 2) begin
        data_valid = (k == 2 * CPB);
        data_in    = 4'b0110;
      end
      if (k == FRAME_CYC - 1) begin
        data_valid = next_valid;
        if (next_valid) data_in = next_w;
      end
      step();
    end
    chk("idle_ready", 32'(data_ready), 32'(1));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_tx", 32'(tx_out), 32'(1));
    chk("idle_done", 32'(frame_done), 32'(0));
    chk("word_hold", 32'(word_out), 32'(w));
    $display("frame word=%b parity=%b accepted at cycle %0d", w, p, last_accept);
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 4'd0;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("rst_tx", 32'(tx_out), 32'(1));
      chk("rst_ready", 32'(data_ready), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_word", 32'(word_out), 32'(0));
      chk("rst_p", 32'(p_out), 32'(0));
      chk("rst_done", 32'(frame_done), 32'(0));
      step();
    end
    $display("reset window checked");

    run_frame(4'b1011, 0, 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < 16; i++)
      run_frame(4'(i), 0, (i < 15), 4'(i + 1), (i > 0));

    run_frame(4'b0001, 2, 1'b0, 4'd0, 1'b0);

    repeat (6) run_frame(4'($urandom), 1, 1'b0, 4'd0, 1'b0);

    // Abort a frame during its parity bit.
    data_in    = 4'b1101;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    repeat (21) step();  // cycle 22 after accept: inside PARITY
    chk("abort_parity_bit", 32'(tx_out), 32'(ref_parity(4'b1101)));
    rst = 1'b1;
    step();
    chk("abort_tx", 32'(tx_out), 32'(1));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_ready", 32'(data_ready), 32'(1));
    chk("abort_done", 32'(frame_done), 32'(0));
    chk("abort_word", 32'(word_out), 32'(0));
    rst = 1'b0;
    $display("frame aborted by reset at cycle %0d", cyc);
    run_frame(4'b0110, 0, 1'b0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pbg_serial_tx.md
# pbg_serial_tx

Parity-bit generator and serial frame transmitter: the sending end of the team's 4-bit parity link. Accepts a 4-bit word over a valid/ready handshake, computes its parity bit, and drives a framed serial line (start, 4 data bits, parity, stop). It also presents the registered word and parity in parallel, so `pbc` can check them directly. `pec` must read 0 for every word this block emits.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 1..255.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `data_in` input 4: word to send; bit 0 is `a`, bit 3 is `d`.
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: block can accept a word.
- `tx_out` output 1: serial line; idles high.
- `word_out` output 4: last accepted word, held until the next accept.
- `p_out` output 1: parity bit of `word_out`.
- `busy` output 1: a frame is in progress.
- `frame_done` output 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP; 3-bit state register.
- IDLE:
  - `data_ready`=1, `tx_out`=1, `busy`=0.
  - On `data_valid` && `data_ready`: capture `data_in` into `word_out`, compute `p_out`, clear the baud counter and bit index, go to START.
- START: `tx_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx_out`=`word_out[idx]`, LSB first.
  - Each bit lasts `CLKS_PER_BIT` cycles.
  - After idx 3, go to PARITY.
- PARITY: `tx_out`=`p_out` for `CLKS_PER_BIT` cycles.
- STOP:
  - `tx_out`=1 for `CLKS_PER_BIT` cycles.
  - `frame_done`=1 in the final cycle, then go to IDLE.
- Parity is the XOR of the 4 data bits (even parity), so that a^b^c^d^p = 0.
- Counters:
  - Baud counter is 8 bits; it counts 0..`CLKS_PER_BIT`-1, then wraps to 0 and advances the bit.
  - Bit index is 2 bits and wraps only via the state exit.
- `data_valid` outside IDLE is ignored. The word is not queued, and `data_in` changes mid-frame do not affect `tx_out`.
- `busy` = (state != IDLE). `data_ready` = (state == IDLE). Both are registered from state, not from inputs.

## Timing
- Reset values: `tx_out`=1, `data_ready`=1, `busy`=0, `frame_done`=0, `word_out`=0, `p_out`=0, state=IDLE.
- `rst` asserted mid-frame aborts the frame. At the next edge, `tx_out`=1 and IDLE is restored; no `frame_done` is produced.
- Accept edge T:
  - `tx_out` falls and `busy` rises, both visible after edge T.
  - `word_out`/`p_out` update at edge T.
- Frame length is 7×`CLKS_PER_BIT` cycles, starting after edge T.
- The `frame_done` cycle is the last STOP cycle. `data_ready` returns high on the following cycle.
- Back-to-back: minimum spacing between accepts is 7×`CLKS_PER_BIT`+1 cycles, because there is one IDLE cycle between frames.
- `CLKS_PER_BIT`=1 is legal: each bit lasts exactly one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `PBG_ODD_PARITY_EN` defined: `p_out` = ~(XOR of the data bits), i.e. odd parity. A standard `pbc` will then flag `pec`=1 on every frame.
- Not defined: even parity as above. This is the default, and it is the build paired with `pbc`.

## Structure
- Shared package `pbg_pkg`:
  - state enum/localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - `FRAME_BITS`=7;
  - `WORD_W`=4.
- Sub-module `pbg_parity_gen`: combinational 4-bit parity with an odd/even select, driven by the macro. It is reused by any future multi-word transmitter.
- Top level holds the FSM, baud counter, bit index and output registers.

## Test plan
- Reset: hold `rst` for 3 cycles, then release with `data_valid`=0 → `tx_out`=1, `data_ready`=1, `busy`=0, `word_out`=0 for 20 cycles.
- Word 4'b1011, `CLKS_PER_BIT`=4:
  - `p_out`=1.
  - `tx_out` sequence, 4 cycles each: 0,1,1,0,1,1,1.
  - `frame_done` pulses at cycle 28 after accept.
  - Feeding `word_out`/`p_out` into `pbc` gives `pec`=0.
- All 16 words back-to-back with `data_valid` held high → each frame is accepted exactly 29 cycles after the previous one, and `pec`=0 for every word.
- `data_valid` pulsed with 4'b0110 during DATA of frame 4'b0001 → second word ignored; `tx_out` data bits are 1,0,0,0 and parity is 1.
- `rst` asserted during PARITY → next cycle `tx_out`=1 and `busy`=0; no `frame_done`; a new word is accepted one cycle after release.
- `PBG_ODD_PARITY_EN` build with 4'b0000 → `p_out`=1, `tx_out` parity bit is 1, and `pbc` reports `pec`=1.
